// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit/receive blocks: FSM state encoding,
// frame geometry and default line-rate constants.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int UART_DATA_BITS   = 8;
    localparam int UART_CLK_FREQ_HZ = 50000000;
    localparam int UART_BAUD_BPS    = 115200;

    // Clocks per serial bit, floored to 2 so that a bit period always has a
    // distinct first and last cycle.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        int div;
        div = clk_freq / baud;
        if (div < 2) begin
            return 2;
        end else begin
            return div;
        end
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// -----------------------------------------------------------------------------
// uart_baud_cnt
// Free-running bit-period counter, 0..CLKS_PER_BIT-1, with a synchronous clear.
// Shared by the UART transmitter and receiver.
// Ports:
//   clk_i      clock
//   rst_i      asynchronous active-high reset
//   clr_i      synchronous clear; counter is 0 on the following cycle
//   bit_end_o  high during the last cycle of a bit period (count == CLKS_PER_BIT-1)
// -----------------------------------------------------------------------------
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_WIDTH    = 9
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic bit_end_o
);

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(CLKS_PER_BIT - 1);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    // Next count: clear wins, otherwise wrap at the end of each bit period.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_q == LAST_CNT) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_end_o = (cnt_q == LAST_CNT);

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_drain
// Drains a first-word-fall-through byte FIFO onto the UART TX pin as 8N1
// frames, LSB first. One pop per frame; the popped byte is held in a local
// shift register so the FIFO head may change freely during the frame.
// Ports:
//   CLK_50        system clock
//   RESET         asynchronous active-high reset
//   TX_ENABLE     level; 1 allows new frames to start
//   FIFO_EMPTY    FIFO empty flag
//   FIFO_RD_DATA  FIFO head byte (valid while FIFO_EMPTY is low)
//   FIFO_RD_EN    one-cycle pop strobe (combinational, IDLE only)
//   UART_TXD      registered serial line, idle high
//   TX_BUSY       high whenever a frame is in progress
//   BYTE_DONE     one-cycle pulse on the last clock of the stop bit
// -----------------------------------------------------------------------------
module uart_tx_fifo_drain
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = UART_CLK_FREQ_HZ,
    parameter int BAUD         = UART_BAUD_BPS,
    parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD),
    parameter int CNT_WIDTH    = 9
) (
    input  logic       CLK_50,
    input  logic       RESET,
    input  logic       TX_ENABLE,
    input  logic       FIFO_EMPTY,
    input  logic [7:0] FIFO_RD_DATA,
    output logic       FIFO_RD_EN,
    output logic       UART_TXD,
    output logic       TX_BUSY,
    output logic       BYTE_DONE
);

    localparam int IDX_W = $clog2(UART_DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UART_DATA_BITS - 1);

    uart_state_e                state_q;
    uart_state_e                state_d;
    logic [UART_DATA_BITS-1:0]  shift_q;
    logic [UART_DATA_BITS-1:0]  shift_d;
    logic [IDX_W-1:0]           idx_q;
    logic [IDX_W-1:0]           idx_d;
    logic                       txd_q;
    logic                       txd_d;

    logic                       pop_s;
    logic                       bit_end_s;
    logic                       cnt_clr_s;

    // Held in reset the block must not pop: the byte could not be latched and
    // would be lost.
    assign pop_s = (state_q == IDLE) && TX_ENABLE && !FIFO_EMPTY && !RESET;

    // The counter idles at zero and restarts on every state change, so each
    // START/DATA/STOP period is exactly CLKS_PER_BIT cycles. Within DATA it
    // wraps by itself between bits.
    assign cnt_clr_s = (state_q == IDLE) || (state_d != state_q);

    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_WIDTH    (CNT_WIDTH)
    ) u_baud_cnt (
        .clk_i     (CLK_50),
        .rst_i     (RESET),
        .clr_i     (cnt_clr_s),
        .bit_end_o (bit_end_s)
    );

    // State, datapath and line registers.
    always_ff @(posedge CLK_50 or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            txd_q   <= txd_d;
        end
    end

    // Next-state, shift register and bit index.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (pop_s) begin
                    shift_d = FIFO_RD_DATA;
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (bit_end_s) begin
                    state_d = DATA;
                    idx_d   = '0;
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = STOP;
                    end else begin
                        shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end else begin
                    state_d = DATA;
                end
            end
            STOP: begin
                if (bit_end_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs. The line level is computed from the next state so that the
    // registered UART_TXD lines up with state_q (start bit begins the cycle
    // after the pop edge).
    always_comb begin
        FIFO_RD_EN = pop_s;
        TX_BUSY    = (state_q != IDLE);
        BYTE_DONE  = (state_q == STOP) && bit_end_s;
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    assign UART_TXD = txd_q;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
module tb_uart_tx_fifo_drain;

    logic       CLK_50       = 1'b0;
    logic       RESET        = 1'b1;
    logic       TX_ENABLE    = 1'b0;
    logic       FIFO_EMPTY   = 1'b1;
    logic [7:0] FIFO_RD_DATA = 8'h00;
    logic       FIFO_RD_EN;
    logic       UART_TXD;
    logic       TX_BUSY;
    logic       BYTE_DONE;

    uart_tx_fifo_drain #(
        .CLKS_PER_BIT (4),
        .CNT_WIDTH    (9)
    ) dut (
        .CLK_50       (CLK_50),
        .RESET        (RESET),
        .TX_ENABLE    (TX_ENABLE),
        .FIFO_EMPTY   (FIFO_EMPTY),
        .FIFO_RD_DATA (FIFO_RD_DATA),
        .FIFO_RD_EN   (FIFO_RD_EN),
        .UART_TXD     (UART_TXD),
        .TX_BUSY      (TX_BUSY),
        .BYTE_DONE    (BYTE_DONE)
    );

    always #10 CLK_50 = ~CLK_50;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    int tests       = 0;
    int fails       = 0;
    int pops        = 0;
    int done_cnt    = 0;
    int frames_done = 0;
    int last_gap    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic refresh_fifo();
        FIFO_EMPTY = (fifo_q.size() == 0);
        FIFO_RD_DATA = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
    endtask

    task automatic push(input logic [7:0] b, input bit expect_tx);
        fifo_q.push_back(b);
        if (expect_tx) exp_q.push_back(b);
        refresh_fifo();
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK_50);
    endtask

    task automatic wait_frames(input int target, input int budget);
        int c = 0;
        while (frames_done < target && c < budget) begin
            @(negedge CLK_50);
            c++;
        end
        check("frame_wait", frames_done, target);
    endtask

    // FIFO model: pop sampled mid-low-phase, applied just after the edge.
    initial begin
        bit pend;
        forever begin
            @(negedge CLK_50);
            #5;
            pend = FIFO_RD_EN;
            @(posedge CLK_50);
            #1;
            if (pend) begin
                if (fifo_q.size() > 0) void'(fifo_q.pop_front());
                pops++;
                refresh_fifo();
            end
        end
    end

    initial begin
        forever begin
            @(negedge CLK_50);
            if (BYTE_DONE) done_cnt++;
        end
    end

    // Monitor: captures each frame sample by sample and compares to scoreboard.
    initial begin
        int gap = 0;
        logic [39:0] rx_v, bd_v, ex_v;
        logic [7:0] e;
        bit busy_ok, aborted;
        forever begin
            @(negedge CLK_50);
            if (RESET) begin
                gap = 0;
            end else if (UART_TXD == 1'b0) begin
                last_gap = gap;
                gap = 0;
                rx_v = '0; bd_v = '0; aborted = 1'b0;
                bd_v[0] = BYTE_DONE;
                busy_ok = TX_BUSY;
                for (int k = 1; k < 40; k++) begin
                    @(negedge CLK_50);
                    if (RESET) begin
                        aborted = 1'b1;
                        break;
                    end
                    rx_v[k] = UART_TXD;
                    bd_v[k] = BYTE_DONE;
                    busy_ok = busy_ok & TX_BUSY;
                end
                if (!aborted) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", {24'h0, rx_v}, 64'h0);
                    end else begin
                        e = exp_q.pop_front();
                        for (int k = 0; k < 40; k++) begin
                            int bp;
                            bp = k / 4;
                            ex_v[k] = (bp == 0) ? 1'b0 : (bp == 9) ? 1'b1 : e[bp-1];
                        end
                        check("frame_line", rx_v, ex_v);
                        check("byte_done_pos", bd_v, 40'h80_0000_0000);
                        check("busy_in_frame", busy_ok, 1'b1);
                    end
                    frames_done++;
                end
            end else begin
                gap++;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, d0, f0, hi;
        refresh_fifo();
        tick(3);
        // Reset state, with a pending byte and TX enabled
        TX_ENABLE = 1'b1;
        push(8'h41, 1'b1);
        #1;
        check("rst_txd", UART_TXD, 1'b1);
        check("rst_busy", TX_BUSY, 1'b0);
        check("rst_done", BYTE_DONE, 1'b0);
        check("rst_rd_en", FIFO_RD_EN, 1'b0);
        tick(1);
        RESET = 1'b0;

        // Test 1: single 'A'
        wait_frames(1, 100);
        tick(5);
        check("t1_pops", pops, 1);
        check("t1_done", done_cnt, 1);
        check("t1_busy", TX_BUSY, 1'b0);

        // Test 2: "Hi" back to back
        p0 = pops; d0 = done_cnt; f0 = frames_done;
        push(8'h48, 1'b1);
        push(8'h69, 1'b1);
        wait_frames(f0 + 2, 200);
        check("t2_gap", last_gap, 1);
        tick(5);
        check("t2_pops", pops - p0, 2);
        check("t2_done", done_cnt - d0, 2);
        check("t2_busy", TX_BUSY, 1'b0);

        // Test 3: TX_ENABLE gating
        TX_ENABLE = 1'b0;
        p0 = pops; f0 = frames_done;
        push(8'h31, 1'b1);
        push(8'h32, 1'b0);
        push(8'h33, 1'b0);
        hi = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (UART_TXD && !FIFO_RD_EN) hi++;
        end
        check("t3_idle_high", hi, 100);
        check("t3_no_pop", pops - p0, 0);
        TX_ENABLE = 1'b1;
        #1;
        check("t3_rd_en", FIFO_RD_EN, 1'b1);
        tick(3);
        TX_ENABLE = 1'b0;
        wait_frames(f0 + 1, 100);
        tick(60);
        check("t3_pops", pops - p0, 1);
        check("t3_frames", frames_done - f0, 1);
        check("t3_busy", TX_BUSY, 1'b0);

        // Test 4: reset mid-frame
        fifo_q.delete();
        refresh_fifo();
        p0 = pops; f0 = frames_done;
        push(8'h55, 1'b0);
        push(8'h33, 1'b1);
        TX_ENABLE = 1'b1;
        hi = 0;
        while (UART_TXD !== 1'b0 && hi < 20) begin
            tick(1);
            hi++;
        end
        check("t4_start_seen", UART_TXD, 1'b0);
        d0 = done_cnt;
        repeat (15) @(posedge CLK_50);
        #2;
        RESET = 1'b1;
        #1;
        check("t4_txd_async", UART_TXD, 1'b1);
        check("t4_busy_async", TX_BUSY, 1'b0);
        tick(2);
        check("t4_no_done", done_cnt - d0, 0);
        RESET = 1'b0;
        wait_frames(f0 + 1, 200);
        tick(5);
        check("t4_pops", pops - p0, 2);
        check("t4_done", done_cnt - d0, 1);

        // Test 5: all-zero and all-one bytes
        f0 = frames_done;
        push(8'h00, 1'b1);
        push(8'hFF, 1'b1);
        wait_frames(f0 + 2, 200);
        check("t5_gap", last_gap, 1);

        // Test 6: FIFO empty throughout
        tick(5);
        p0 = pops;
        hi = 0;
        for (int i = 0; i < 1000; i++) begin
            tick(1);
            if (UART_TXD && !FIFO_RD_EN && !TX_BUSY) hi++;
        end
        check("t6_idle", hi, 1000);
        check("t6_no_pop", pops - p0, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
